// File: rtl/hps_arb_pkg.sv
// Shared state encoding and constants for the HPS FPGA-channel arbiter.
package hps_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    ACTIVE  = 2'd2,
    DISCARD = 2'd3
  } arb_state_e;

  localparam logic [15:0] DISCARD_READ = 16'hFFFF;
  localparam logic [7:0]  ERR_MAX      = 8'hFF;

  // Every error cause funnels through here so the counter never wraps.
  function automatic logic [7:0] err_bump(input logic [7:0] cnt);
    return (cnt == ERR_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/hps_arb_timeout.sv
// Consecutive-wait counter: clears on clr, counts on en, pulses expire on the
// TO_CYC-th consecutive enabled cycle.
module hps_arb_timeout #(
  parameter int TO_CYC = 65535
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  // One spare count so the counter can step past LAST without wrapping.
  localparam int              CW   = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0]   LAST = CW'(TO_CYC - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)   cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= cnt + CW'(1);
  end

  assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/hps_fpga_arb.sv
// Routes the HPS FPGA I/O channel to one of NCLI clients chosen by the first
// strobed word of each transaction, with wait timeout and error accounting.
module hps_fpga_arb
  import hps_arb_pkg::*;
#(
  parameter int NCLI   = 4,
  parameter int TO_CYC = 65535
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                fpga_ena,
  input  logic                io_strobe,
  input  logic [15:0]         io_din,
  output logic [15:0]         io_dout,
  output logic                io_wait,
  output logic [NCLI-1:0]     cli_sel,
  output logic                cli_strobe,
  output logic                cli_first,
  output logic [15:0]         cli_din,
  output logic                cli_end,
  input  logic [16*NCLI-1:0]  cli_dout,
  input  logic [NCLI-1:0]     cli_wait,
  output logic [7:0]          err_cnt,
  output logic                busy
);

  localparam int SW = (NCLI > 1) ? $clog2(NCLI) : 1;

  arb_state_e      state, state_d;
  logic [SW-1:0]   sel_idx, sel_idx_d;
  logic            first_flag, first_flag_d;
  logic            end_pend, end_pend_d;
  logic [NCLI-1:0] cli_sel_d;
  logic            cli_strobe_d, cli_first_d, cli_end_d;
  logic [15:0]     cli_din_d, io_dout_d;
  logic [7:0]      err_cnt_d;
  logic            in_active, sel_wait, to_run, to_expire, timeout;
  logic            sel_valid, fwd, err_hit, keep_sel;
  logic [15:0]     sel_dout;

  assign in_active = (state == ACTIVE);
  assign sel_wait  = cli_wait[sel_idx];
  assign sel_dout  = cli_dout[16*sel_idx +: 16];
  assign sel_valid = int'(io_din[7:0]) < NCLI;

  assign to_run = in_active && sel_wait;

  hps_arb_timeout #(.TO_CYC(TO_CYC)) u_timeout (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clr     (!to_run),
    .en      (to_run),
    .expire  (to_expire)
  );

  // A falling fpga_ena ends the transaction normally, so it outranks the timeout.
  assign timeout = to_expire && fpga_ena;
  assign io_wait = to_run && !timeout;
  assign busy    = (state != IDLE);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    state_d      = state;
    sel_idx_d    = sel_idx;
    first_flag_d = first_flag;
    end_pend_d   = 1'b0;
    cli_end_d    = end_pend;
    cli_strobe_d = 1'b0;
    cli_first_d  = 1'b0;
    cli_din_d    = cli_din;
    err_cnt_d    = err_cnt;
    io_dout_d    = '0;
    fwd          = 1'b0;
    err_hit      = 1'b0;

    case (state)
      IDLE: if (fpga_ena) state_d = SELECT;
      SELECT: begin
        if (!fpga_ena) state_d = IDLE;
        else if (io_strobe) begin
          if (sel_valid) begin
            state_d      = ACTIVE;
            sel_idx_d    = io_din[SW-1:0];
            first_flag_d = 1'b1;
          end else begin
            state_d = DISCARD;
            err_hit = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (!fpga_ena) begin
          state_d = IDLE;
          // A last strobe is still delivered; cli_end then trails it by a cycle.
          if (io_strobe && !sel_wait) begin
            fwd        = 1'b1;
            end_pend_d = 1'b1;
          end else begin
            cli_end_d = 1'b1;
            err_hit   = io_strobe;
          end
        end else if (timeout) begin
          state_d   = DISCARD;
          cli_end_d = 1'b1;
          err_hit   = 1'b1;
        end else if (io_strobe) begin
          if (sel_wait) err_hit = 1'b1;
          else          fwd     = 1'b1;
        end
      end
      DISCARD: if (!fpga_ena) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fwd) begin
      cli_strobe_d = 1'b1;
      cli_first_d  = first_flag;
      first_flag_d = 1'b0;
      cli_din_d    = io_din;
    end
    if (err_hit) err_cnt_d = err_bump(err_cnt);

    // cli_sel stays valid through the closing cli_end pulse.
    keep_sel = (state_d == ACTIVE) || cli_end_d || end_pend_d;
    for (int k = 0; k < NCLI; k++) cli_sel_d[k] = keep_sel && (sel_idx_d == SW'(k));

    if (state_d == DISCARD)                io_dout_d = DISCARD_READ;
    else if (in_active && state_d == ACTIVE) io_dout_d = sel_dout;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel_idx    <= '0;
      first_flag <= 1'b0;
      end_pend   <= 1'b0;
      cli_sel    <= '0;
      cli_strobe <= 1'b0;
      cli_first  <= 1'b0;
      cli_din    <= '0;
      cli_end    <= 1'b0;
      io_dout    <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_d;
      sel_idx    <= sel_idx_d;
      first_flag <= first_flag_d;
      end_pend   <= end_pend_d;
      cli_sel    <= cli_sel_d;
      cli_strobe <= cli_strobe_d;
      cli_first  <= cli_first_d;
      cli_din    <= cli_din_d;
      cli_end    <= cli_end_d;
      io_dout    <= io_dout_d;
      err_cnt    <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_hps_fpga_arb.sv
// Self-checking bench for hps_fpga_arb: directed scenarios plus random
// transactions, all compared every cycle against a transaction-level model.
module tb_hps_fpga_arb;

  localparam int NCLI   = 4;
  localparam int TO_CYC = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        fpga_ena, io_strobe;
  logic [15:0] io_din, io_dout;
  logic        io_wait;
  logic [3:0]  cli_sel;
  logic        cli_strobe, cli_first, cli_end;
  logic [15:0] cli_din;
  logic [63:0] cli_dout;
  logic [3:0]  cli_wait;
  logic [7:0]  err_cnt;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 0;

  always #5 clk_sys = ~clk_sys;

  hps_fpga_arb #(.NCLI(NCLI), .TO_CYC(TO_CYC)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .fpga_ena   (fpga_ena),
    .io_strobe  (io_strobe),
    .io_din     (io_din),
    .io_dout    (io_dout),
    .io_wait    (io_wait),
    .cli_sel    (cli_sel),
    .cli_strobe (cli_strobe),
    .cli_first  (cli_first),
    .cli_din    (cli_din),
    .cli_end    (cli_end),
    .cli_dout   (cli_dout),
    .cli_wait   (cli_wait),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: which phase the channel is in, which client owns
  // it, how long that client has been waiting, and what each output should show.
  localparam int M_IDLE = 0, M_SEL = 1, M_ACT = 2, M_DISC = 3;
  int          m_phase, m_client, m_run, m_err;
  bit          m_first_owed, m_end_owed, m_selv, m_strobe, m_first, m_end;
  logic [15:0] m_din, m_dout;

  task automatic model_reset();
    m_phase = M_IDLE; m_client = 0; m_run = 0; m_err = 0;
    m_first_owed = 0; m_end_owed = 0; m_selv = 0;
    m_strobe = 0; m_first = 0; m_end = 0; m_din = '0; m_dout = '0;
  endtask

  task automatic model_step();
    int nxt;
    bit waiting, fwd, err, endp, pend;
    nxt = m_phase; fwd = 0; err = 0; endp = m_end_owed; pend = 0;
    waiting = (m_phase == M_ACT) && cli_wait[m_client];
    case (m_phase)
      M_IDLE: if (fpga_ena) nxt = M_SEL;
      M_SEL: begin
        if (!fpga_ena) nxt = M_IDLE;
        else if (io_strobe) begin
          if (io_din[7:0] < NCLI) begin
            nxt = M_ACT; m_client = int'(io_din[7:0]); m_first_owed = 1;
          end else begin
            nxt = M_DISC; err = 1;
          end
        end
      end
      M_ACT: begin
        if (!fpga_ena) begin
          nxt = M_IDLE;
          if (io_strobe && !waiting) begin fwd = 1; pend = 1; end
          else begin endp = 1; err = io_strobe; end
        end else if (waiting && m_run == TO_CYC - 1) begin
          nxt = M_DISC; err = 1; endp = 1;
        end else if (io_strobe) begin
          if (waiting) err = 1; else fwd = 1;
        end
      end
      default: if (!fpga_ena) nxt = M_IDLE;
    endcase
    m_run = waiting ? m_run + 1 : 0;
    if (nxt == M_DISC)                      m_dout = 16'hFFFF;
    else if (m_phase == M_ACT && nxt == M_ACT) m_dout = cli_dout[16*m_client +: 16];
    else                                    m_dout = '0;
    m_strobe = fwd;
    if (fwd) begin m_first = m_first_owed; m_first_owed = 0; m_din = io_din; end
    else m_first = 0;
    m_end = endp;
    m_end_owed = pend;
    if (err && m_err < 255) m_err++;
    m_phase = nxt;
    m_selv = (nxt == M_ACT) || endp || pend;
  endtask

  task automatic compare();
    logic [3:0] es;
    bit ew;
    es = '0;
    if (m_selv) es[m_client] = 1'b1;
    ew = (m_phase == M_ACT) && cli_wait[m_client] && !(fpga_ena && m_run == TO_CYC - 1);
    check("cmp_busy", busy, m_phase != M_IDLE);
    check("cmp_io_wait", io_wait, ew);
    check("cmp_io_dout", io_dout, m_dout);
    check("cmp_cli_sel", cli_sel, es);
    check("cmp_cli_strobe", cli_strobe, m_strobe);
    check("cmp_cli_first", cli_first, m_first);
    check("cmp_cli_din", cli_din, m_din);
    check("cmp_cli_end", cli_end, m_end);
    check("cmp_err_cnt", err_cnt, m_err);
  endtask

  // Inputs change just after posedge, so at negedge they are the values the next edge samples.
  initial begin
    model_reset();
    forever begin
      @(negedge clk_sys);
      if (!reset_n) model_reset();
      if (chk_on) compare();
      if (reset_n) model_step();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive(input bit ena, input bit stb, input logic [15:0] d);
    fpga_ena = ena; io_strobe = stb; io_din = d;
  endtask

  // Leaves the channel in ACTIVE for client c with ena high and no strobe.
  task automatic open_client(input int c);
    drive(1, 0, '0); tick();
    drive(1, 1, 16'(c)); tick();
    drive(1, 0, '0);
  endtask

  task automatic close_txn();
    drive(0, 0, '0);
    tick(); tick(); tick();
  endtask

  int n_wait, n_end, len;
  bit hold, stb;
  logic [15:0] din;

  initial begin
    reset_n = 1'b0;
    drive(0, 0, '0);
    cli_dout = '0;
    cli_wait = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk_on = 1;
    check("rst_busy", busy, 0);
    check("rst_cli_sel", cli_sel, 0);
    check("rst_err", err_cnt, 0);
    reset_n = 1'b1;
    tick();

    // Select client 2 and forward two words.
    open_client(2);
    check("t1_sel", cli_sel, 4'b0100);
    drive(1, 1, 16'h1234); tick();
    check("t1_stb1", cli_strobe, 1);
    check("t1_din1", cli_din, 16'h1234);
    check("t1_first1", cli_first, 1);
    drive(1, 1, 16'h5678); tick();
    check("t1_stb2", cli_strobe, 1);
    check("t1_din2", cli_din, 16'h5678);
    check("t1_first2", cli_first, 0);
    drive(0, 0, '0); tick();
    check("t1_end", cli_end, 1);
    check("t1_end_sel", cli_sel, 4'b0100);
    tick();
    check("t1_end_off", cli_end, 0);
    check("t1_sel_clr", cli_sel, 0);
    tick();

    // Read path from client 1.
    cli_dout = {16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    open_client(1);
    check("t2_dout_first", io_dout, 16'h0000);
    tick();
    check("t2_dout", io_dout, 16'hBEEF);
    drive(0, 0, '0); tick();
    check("t2_dout_idle", io_dout, 16'h0000);
    tick(); tick();

    // Invalid select lands in DISCARD.
    drive(1, 0, '0); tick();
    drive(1, 1, 16'h0007); tick();
    check("t3_err", err_cnt, 1);
    check("t3_dout", io_dout, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 16'(i + 1)); tick();
      check("t3_no_stb", cli_strobe, 0);
    end
    close_txn();

    // Client 0 waits forever: timeout after TO_CYC wait cycles.
    open_client(0);
    cli_wait = 4'b0001;
    n_wait = 0; n_end = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (io_wait) n_wait++;
      tick();
      if (cli_end) n_end++;
    end
    check("t4_wait_cycles", n_wait, TO_CYC - 1);
    check("t4_end_pulses", n_end, 1);
    check("t4_err", err_cnt, 2);
    check("t4_dout", io_dout, 16'hFFFF);
    check("t4_sel", cli_sel, 0);
    cli_wait = '0;
    close_txn();

    // Strobe while waiting is dropped; after wait drops it forwards.
    open_client(3);
    cli_wait = 4'b1000;
    drive(1, 1, 16'hAAAA); tick();
    check("t5_drop", cli_strobe, 0);
    check("t5_err", err_cnt, 3);
    drive(1, 0, '0); cli_wait = '0; tick();
    drive(1, 1, 16'h5555); tick();
    check("t5_fwd", cli_strobe, 1);
    check("t5_din", cli_din, 16'h5555);
    check("t5_first", cli_first, 1);
    close_txn();

    // ena falls together with a strobe: strobe first, then cli_end.
    open_client(0);
    drive(0, 1, 16'h1111); tick();
    check("t6_stb", cli_strobe, 1);
    check("t6_no_end", cli_end, 0);
    check("t6_sel", cli_sel, 4'b0001);
    drive(0, 0, '0); tick();
    check("t6_end", cli_end, 1);
    check("t6_end_sel", cli_sel, 4'b0001);
    tick();
    check("t6_sel_clr", cli_sel, 0);
    tick();

    // Asynchronous reset mid-transaction.
    open_client(2);
    drive(1, 1, 16'h9999); tick();
    #2 reset_n = 1'b0;
    #1;
    check("t7_busy", busy, 0);
    check("t7_sel", cli_sel, 0);
    check("t7_stb", cli_strobe, 0);
    check("t7_din", cli_din, 0);
    check("t7_err", err_cnt, 0);
    drive(0, 0, '0);
    n_end = 0;
    repeat (3) begin tick(); if (cli_end) n_end++; end
    check("t7_no_end", n_end, 0);
    reset_n = 1'b1;
    tick(); tick();

    // Random transactions.
    for (int t = 0; t < 150; t++) begin
      len  = $urandom_range(3, 40);
      hold = ($urandom_range(0, 4) == 0);
      for (int c = 0; c < len; c++) begin
        cli_dout = {32'($urandom), 32'($urandom)};
        cli_wait = hold ? 4'hF : (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
        stb = ($urandom_range(0, 9) < 4);
        din = (c < 3) ? {8'($urandom), 8'($urandom_range(0, 4))} : 16'($urandom);
        drive(1, stb, din); tick();
      end
      cli_wait = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      drive(0, $urandom_range(0, 1) == 1, 16'($urandom)); tick();
      repeat ($urandom_range(1, 3)) begin
        drive(0, $urandom_range(0, 1) == 1, 16'($urandom)); tick();
      end
    end

    // Saturation: reset, then 300 invalid selects.
    drive(0, 0, '0); cli_wait = '0;
    reset_n = 1'b0; tick(); tick();
    reset_n = 1'b1; tick();
    check("t8_err_zero", err_cnt, 0);
    for (int t = 0; t < 300; t++) begin
      drive(1, 0, '0); tick();
      drive(1, 1, {8'($urandom), 8'($urandom_range(4, 255))}); tick();
      drive(0, 0, '0); tick(); tick();
    end
    check("t8_err_sat", err_cnt, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
